// File: rtl/modulo_scan_mux4_1.sv
// rtl/modulo_scan_mux4_1.sv - four-channel scanning collector, one slot of DIV clocks per channel
module modulo_scan_mux4_1 #(
  parameter int DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [3:0] i_in,
  output logic [1:0] o_sel,
  output logic       o_data_out,
  output logic [3:0] o_snapshot,
  output logic       o_frame_valid,
  output logic       o_changed,
  output logic       o_busy
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LP_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] LP_ONE  = PW'(1);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t        r_state;
  logic [1:0]    r_sel;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_shadow;
  logic [3:0]    r_snapshot;
  logic          r_data_out;
  logic          r_frame_valid;
  logic          r_changed;
  logic          r_busy;

  logic [1:0]    w_ch;
  logic          w_bit;
  logic [3:0]    w_merged;
  logic          w_slot_end;

  // Slot s maps to channel 3-s, i.e. the bitwise inverse of the select.
  always_comb begin
    w_ch           = ~r_sel;
    w_bit          = i_in[w_ch];
    w_merged       = r_shadow;
    w_merged[w_ch] = w_bit;
    w_slot_end     = (r_presc == LP_LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_sel         <= 2'b00;
      r_presc       <= '0;
      r_shadow      <= 4'b0000;
      r_snapshot    <= 4'b0000;
      r_data_out    <= 1'b0;
      r_frame_valid <= 1'b0;
      r_changed     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_changed     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sel      <= 2'b00;
          r_presc    <= '0;
          r_data_out <= 1'b0;
          if (i_en) begin
            r_state <= ST_SCAN;
            r_busy  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (!i_en) begin
            // Abort wins over a coinciding frame end: the partial frame is dropped.
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_sel      <= 2'b00;
            r_presc    <= '0;
            r_shadow   <= 4'b0000;
            r_data_out <= 1'b0;
          end else begin
            r_data_out <= w_bit;
            if (w_slot_end) begin
              r_presc  <= '0;
              r_sel    <= r_sel + 2'b01;
              r_shadow <= w_merged;
              if (r_sel == 2'b11) begin
                r_snapshot    <= w_merged;
                r_frame_valid <= 1'b1;
                r_changed     <= (w_merged != r_snapshot);
              end
            end else begin
              r_presc <= r_presc + LP_ONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_sel         = r_sel;
  assign o_data_out    = r_data_out;
  assign o_snapshot    = r_snapshot;
  assign o_frame_valid = r_frame_valid;
  assign o_changed     = r_changed;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_modulo_scan_mux4_1.sv
// tb/tb_modulo_scan_mux4_1.sv - self-checking bench for modulo_scan_mux4_1 (DIV=4 and DIV=1)
module tb_modulo_scan_mux4_1;

  logic       clk;
  logic       rst_n;
  logic       en4, en1;
  logic [3:0] in4, in1;

  logic [1:0] sel4, sel1;
  logic       dout4, dout1;
  logic [3:0] snap4, snap1;
  logic       fv4, fv1;
  logic       chg4, chg1;
  logic       busy4, busy1;
  logic [9:0] all4;

  assign all4 = {sel4, dout4, snap4, fv4, chg4, busy4};

  modulo_scan_mux4_1 #(.DIV(4)) u_div4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en4), .i_in(in4),
    .o_sel(sel4), .o_data_out(dout4), .o_snapshot(snap4),
    .o_frame_valid(fv4), .o_changed(chg4), .o_busy(busy4)
  );

  modulo_scan_mux4_1 #(.DIV(1)) u_div1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en1), .i_in(in1),
    .o_sel(sel1), .o_data_out(dout1), .o_snapshot(snap1),
    .o_frame_valid(fv1), .o_changed(chg1), .o_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in;
    logic [3:0] snap;
    logic       chg;
  } vec_t;

  typedef struct {
    logic [3:0] snap;
    logic       chg;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge, sample 1 time unit later and retire scoreboard entries on frame_valid.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (fv4) begin
      if (q.size() == 0) begin
        check("unexpected frame_valid", 32'(fv4), 32'd0);
      end else begin
        e = q.pop_front();
        check("frame snapshot", 32'(snap4), 32'(e.snap));
        check("frame changed", 32'(chg4), 32'(e.chg));
      end
    end else if (chg4) begin
      check("changed without frame_valid", 32'(chg4), 32'd0);
    end
  endtask

  task automatic push_exp(input logic [3:0] s, input logic c);
    exp_t e;
    e.snap = s;
    e.chg  = c;
    q.push_back(e);
  endtask

  // One full DIV=4 frame; bit 2 is forced high for the edges lo..hi.
  task automatic frame16(input logic [3:0] v, input int lo, input int hi, input logic exp_fv);
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] cur;
      int         idx;
      cur = v;
      if (k >= lo && k <= hi) cur[2] = 1'b1;
      in4 = cur;
      idx = 3 - ((k - 1) / 4) % 4;
      tick();
      check("sel", 32'(sel4), 32'((k / 4) % 4));
      check("data_out", 32'(dout4), 32'(cur[idx]));
      check("frame_valid timing", 32'(fv4), 32'(exp_fv && k == 16));
      check("busy", 32'(busy4), 32'd1);
    end
  endtask

  initial begin
    tbl[0] = '{in: 4'b1010, snap: 4'b1010, chg: 1'b1};
    tbl[1] = '{in: 4'b1010, snap: 4'b1010, chg: 1'b0};
    tbl[2] = '{in: 4'b0101, snap: 4'b0101, chg: 1'b1};
    tbl[3] = '{in: 4'b0000, snap: 4'b0000, chg: 1'b1};
    tbl[4] = '{in: 4'b0000, snap: 4'b0000, chg: 1'b0};
    tbl[5] = '{in: 4'b1111, snap: 4'b1111, chg: 1'b1};

    rst_n = 1'b0;
    en4 = 1'b0; en1 = 1'b0;
    in4 = 4'b0000; in1 = 4'b0000;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset state div4", 32'(all4), 32'd0);
    check("reset state div1", 32'({sel1, dout1, snap1, fv1, chg1, busy1}), 32'd0);

    // Asynchronous reset in the middle of a scan.
    en4 = 1'b1; in4 = 4'b1010;
    tick();
    repeat (6) tick();
    check("busy before reset", 32'(busy4), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'(all4), 32'd0);
    tick();
    tick();
    en4 = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle after reset", 32'(all4), 32'd0);
    end

    // Back-to-back frames from the vector table.
    en4 = 1'b1; in4 = tbl[0].in;
    tick();
    check("E0 busy", 32'(busy4), 32'd1);
    check("E0 sel", 32'(sel4), 32'd0);
    for (int i = 0; i < 6; i++) begin
      push_exp(tbl[i].snap, tbl[i].chg);
      frame16(tbl[i].in, 0, -1, 1'b1);
    end
    en4 = 1'b0;
    tick();
    check("idle busy", 32'(busy4), 32'd0);

    // Abort at E0+10, then a full frame after re-enable.
    en4 = 1'b1; in4 = 4'b0000;
    tick();
    repeat (9) tick();
    check("pre-abort sel", 32'(sel4), 32'd2);
    en4 = 1'b0;
    tick();
    check("abort busy", 32'(busy4), 32'd0);
    check("abort sel", 32'(sel4), 32'd0);
    check("abort data_out", 32'(dout4), 32'd0);
    check("abort snapshot held", 32'(snap4), 32'hf);
    repeat (20) tick();
    check("idle snapshot held", 32'(snap4), 32'hf);
    en4 = 1'b1;
    tick();
    push_exp(4'b0000, 1'b1);
    frame16(4'b0000, 0, -1, 1'b1);

    // Mid-slot pulse is ignored; a pulse held through the slot end is captured.
    push_exp(4'b0000, 1'b0);
    frame16(4'b0000, 6, 6, 1'b1);
    push_exp(4'b0100, 1'b1);
    frame16(4'b0000, 6, 8, 1'b1);

    // en dropped exactly on the frame-end edge.
    in4 = 4'b1111;
    repeat (15) tick();
    check("pre-collision sel", 32'(sel4), 32'd3);
    en4 = 1'b0;
    tick();
    check("collision frame_valid", 32'(fv4), 32'd0);
    check("collision busy", 32'(busy4), 32'd0);
    check("collision sel", 32'(sel4), 32'd0);
    check("collision snapshot", 32'(snap4), 32'h4);
    repeat (5) tick();
    check("scoreboard drained", 32'(q.size()), 32'd0);

    // DIV=1: one clock per slot.
    en1 = 1'b1; in1 = 4'b0110;
    tick();
    check("div1 E0 sel", 32'(sel1), 32'd0);
    check("div1 E0 busy", 32'(busy1), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] v;
      v = in1;
      tick();
      check("div1 sel", 32'(sel1), 32'(k % 4));
      check("div1 data_out", 32'(dout1), 32'(v[3 - (k - 1) % 4]));
      check("div1 frame_valid", 32'(fv1), 32'(k % 4 == 0));
      if (fv1) begin
        check("div1 snapshot", 32'(snap1), 32'h6);
        check("div1 changed", 32'(chg1), 32'(k == 4));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/modulo_scan_mux4_1.md
# modulo_scan_mux4_1

Four-channel scanning collector: the gathering side of the 1-to-4 select/distribute scheme. It cycles a 2-bit select through the four channel slots, samples one input line per slot, and publishes a 4-bit snapshot once per completed frame. It sits between four slow single-bit sources, such as keypad rows or sensor lines driven through the 1-to-4 demux, and the control logic that consumes the assembled vector.

## Interface
- DIV, default 4: clocks per slot; legal range ≥ 1; prescaler width is ceil(log2(DIV)), minimum 1.
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  scan enable, sampled on clk.
- in  input  4  channel input lines.
- sel  output  2  current slot select; drives the companion 1-to-4 demux select.
- data_out  output  1  registered value of the currently selected channel.
- snapshot  output  4  last completed frame, indexed by channel.
- frame_valid  output  1  one-cycle pulse when snapshot updates.
- changed  output  1  high for the frame_valid cycle if the new snapshot differs from the previous one.
- busy  output  1  high while in SCAN.

## Operation
- Slot-to-channel map, identical to the distribute side:
  - sel=00 → channel 3
  - sel=01 → channel 2
  - sel=10 → channel 1
  - sel=11 → channel 0
- ch(sel) denotes this map.
- States:
  - IDLE: sel=00, prescaler=0, busy=0, data_out=0.
  - SCAN: busy=1.
- Transitions:
  - IDLE→SCAN on a clk edge with en=1; sel=00 and prescaler=0 after that edge.
  - SCAN→IDLE on any clk edge with en=0. The partial frame (shadow register) is discarded; snapshot holds its value; no frame_valid is issued.
- SCAN, every edge:
  - data_out ← in[ch(sel)], with sel taken before the edge.
  - prescaler increments.
- SCAN, edge with prescaler=DIV-1 (slot end):
  - shadow[ch(sel)] ← in[ch(sel)].
  - prescaler ← 0.
  - sel ← sel+1, wrapping 11→00.
- Slot end with sel=11 (frame end):
  - snapshot ← shadow, with the bit sampled on this edge merged in.
  - frame_valid ← 1.
  - changed ← (new snapshot ≠ old snapshot).
  - Scanning continues with sel=00 if en=1.
- frame_valid and changed drop to 0 on the next edge. changed is 0 whenever frame_valid is 0.
- en=0 on a frame-end edge: SCAN→IDLE takes priority; no snapshot update.
- First frame after entering SCAN: changed is computed against the current snapshot, which is 0 after reset.
- Input changes in mid-slot are ignored; only the value on the slot-end edge counts.
- DIV=1: each slot lasts one clock, and sel changes on every edge.

## Timing
- Reset (asynchronous assert, release synchronous to clk):
  - state=IDLE, sel=00, prescaler=0, shadow=0000.
  - data_out=0, snapshot=0000, frame_valid=0, changed=0, busy=0.
- Reset mid-frame aborts immediately, with all outputs at their reset values.
- Slot length is DIV clocks; frame length is 4·DIV clocks.
- en is sampled at edge E0 (entering SCAN).
  - sel steps at E0+DIV, E0+2·DIV, E0+3·DIV, then wraps at E0+4·DIV.
  - frame_valid is high during the cycle after edge E0+4·DIV.
  - Frames then repeat every 4·DIV clocks.
- data_out latency is 1 clock relative to sel and in.
- sel, data_out, snapshot, frame_valid, changed and busy are all registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 mid-SCAN with DIV=4 → all outputs 0 and sel=00 immediately; remain so for 10 clocks after release with en=0.
- Basic frame: DIV=4, in=4'b1010 held, en=1 from E0 →
  - sel sequence 00,01,10,11 changing every 4 clocks;
  - frame_valid pulse after E0+16;
  - snapshot=1010, changed=1.
  - Second frame after E0+32: snapshot=1010, changed=0.
- Slot sampling: DIV=4, in=0000. Raise in[2] during slot sel=01, at prescaler=1, and lower it at prescaler=2 → snapshot bit 2=0. Repeat, holding in[2] through the slot-end edge → bit 2=1.
- Abort: DIV=4, drop en at E0+10 → IDLE next edge; busy=0, sel=00, no frame_valid, snapshot unchanged. Re-enable → full 16-clock frame before the next frame_valid.
- Frame-end collision: en=0 exactly on edge E0+16 → no frame_valid, no snapshot update.
- DIV=1: in=4'b0110, en=1 → sel changes every clock; frame_valid every 4 clocks; snapshot=0110.
